shiftout_receiver: RTL

Serial receiver that sits directly upstream of the multi-console output stage and produces its 12-bit button vector (`shiftout_in[11:0]`, active-low, 1 = released). The host microcontroller frames each controller report with a latch strobe and shifts 12 bits over a clock/data pair. This block synchronises those asynchronous pins into `system_clock`, validates frame length, and commits only complete frames. A watchdog releases all buttons if the host stops sending.

---
 rtl/shiftout_receiver_if.sv | 23 ++
 rtl/shiftout_receiver.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/shiftout_receiver_if.sv
// MCU serial pins in, committed button vector and frame status out.
// The receiver uses the slave modport; the MCU side or a bench uses master.
interface shiftout_receiver_if #(
  parameter int WIDTH = 12
) ();
  logic             mcu_clk;
  logic             mcu_latch;
  logic             mcu_data;
  logic [WIDTH-1:0] buttons;
  logic             frame_valid;
  logic             frame_error;
  logic             timeout;

  modport master (
    output mcu_clk, mcu_latch, mcu_data,
    input  buttons, frame_valid, frame_error, timeout
  );

  modport slave (
    input  mcu_clk, mcu_latch, mcu_data,
    output buttons, frame_valid, frame_error, timeout
  );
endinterface

// File: rtl/shiftout_receiver.sv
// Latched serial frame receiver feeding the active-low button vector; no backpressure.
// Pin-to-detect SYNC_STAGES+1 cycles, pin-to-buttons/frame_valid SYNC_STAGES+2 cycles.
module shiftout_receiver #(
  parameter int WIDTH          = 12,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic               system_clock,
  input  logic               reset,
  shiftout_receiver_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES > 1 ? TIMEOUT_CYCLES : 2);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
  localparam int P_CLK = 0;
  localparam int P_LAT = 1;
  localparam int P_DAT = 2;

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } state_t;

  logic [2:0]                   pins;
  logic [SYNC_STAGES-1:0][2:0]  sync_q, sync_d;
  logic [2:0]                   sync_last;
  logic [1:0]                   prev_q, prev_d;
  logic                         clk_rise, lat_rise, lat_fall, data_s;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [WIDTH-1:0]             shreg_q, shreg_d;
  logic                         commit_q, commit_d;
  logic                         discard_q, discard_d;

  logic [WIDTH-1:0]             buttons_q, buttons_d;
  logic                         frame_valid_q, frame_valid_d;
  logic                         frame_error_q, frame_error_d;
  logic                         timeout_q, timeout_d;
  logic [WD_W-1:0]              wd_q, wd_d;

  assign pins      = {bus.mcu_data, bus.mcu_latch, bus.mcu_clk};
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign clk_rise  =  sync_last[P_CLK] & ~prev_q[P_CLK];
  assign lat_rise  =  sync_last[P_LAT] & ~prev_q[P_LAT];
  assign lat_fall  = ~sync_last[P_LAT] &  prev_q[P_LAT];
  assign data_s    =  sync_last[P_DAT];

  // All three pins share one chain depth so data lines up with its clock edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pins};
    prev_d = sync_last[1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    commit_d  = 1'b0;
    discard_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lat_rise) begin
          state_d = ST_FRAME;
          cnt_d   = '0;
          shreg_d = '1;
        end
      end
      ST_FRAME: begin
        // Latch fall wins over a coincident clock edge: that bit is dropped.
        if (lat_fall) begin
          state_d   = ST_IDLE;
          commit_d  = (cnt_q == CNT_FULL);
          discard_d = (cnt_q != CNT_FULL);
        end else if (clk_rise) begin
          shreg_d = {shreg_q[WIDTH-2:0], data_s};
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    buttons_d     = buttons_q;
    timeout_d     = timeout_q;
    wd_d          = wd_q;
    frame_valid_d = commit_q;
    frame_error_d = discard_q;
    if (commit_q) begin
      buttons_d = shreg_q;
      timeout_d = 1'b0;
      wd_d      = WD_LOAD;
    end else if (wd_q == '0) begin
      // Host went silent: release everything and hold expired.
      buttons_d = '1;
      timeout_d = 1'b1;
    end else begin
      wd_d = wd_q - 1'b1;
    end
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      sync_q        <= '0;
      prev_q        <= '0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      shreg_q       <= '1;
      commit_q      <= 1'b0;
      discard_q     <= 1'b0;
      buttons_q     <= '1;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      timeout_q     <= 1'b0;
      wd_q          <= WD_LOAD;
    end else begin
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      commit_q      <= commit_d;
      discard_q     <= discard_d;
      buttons_q     <= buttons_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      timeout_q     <= timeout_d;
      wd_q          <= wd_d;
    end
  end

  assign bus.buttons     = buttons_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.timeout     = timeout_q;
endmodule
